timepulse_gen: RTL and testbench

Generates the one-hot timepulse sequence T01..T12 that gates the NOR-gate logic of each memory cycle time (MCT), plus a sub-pulse phase index and an end-of-MCT strobe. It sits directly upstream of the NOR-gate fabric: every timepulse-qualified gate input is driven from this block's registered outputs. It also implements the stop/single-step and restart controls that freeze or re-align the sequence.

---
 rtl/timepulse_gen_pkg.sv | 35 +++
 rtl/timepulse_gen_if.sv | 27 ++
 rtl/timepulse_gen_tp_ring.sv | 31 +++
 rtl/timepulse_gen.sv | 115 +++++++++++
 tb/tb_timepulse_gen.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/timepulse_gen_pkg.sv
// Shared timing constants, timepulse vector type and run/stop state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package agc_timing_pkg;

  localparam int N_TP_DEF          = 12;
  localparam int PHASES_PER_TP_DEF = 4;

  // Bit index of each timepulse inside the one-hot vector
  localparam int TP_T01 = 0;
  localparam int TP_T02 = 1;
  localparam int TP_T03 = 2;
  localparam int TP_T04 = 3;
  localparam int TP_T05 = 4;
  localparam int TP_T06 = 5;
  localparam int TP_T07 = 6;
  localparam int TP_T08 = 7;
  localparam int TP_T09 = 8;
  localparam int TP_T10 = 9;
  localparam int TP_T11 = 10;
  localparam int TP_T12 = 11;

  typedef logic [N_TP_DEF-1:0] tp_vec_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_STOPPED = 1'b1
  } run_state_e;

  // Phase counter width; never narrower than one bit
  function automatic int phase_w(input int phases);
    return (phases < 2) ? 1 : $clog2(phases);
  endfunction

endpackage

// File: rtl/timepulse_gen_if.sv
// Control inputs and timepulse outputs of timepulse_gen.
// Latency: n/a (wiring only).
// Backpressure: none; the master drives controls, the slave returns registered status.
interface timepulse_gen_if #(
  parameter int N_TP = 12,
  parameter int PW   = 2
) ();
  logic            en;
  logic            stop;
  logic            step;
  logic            restart;
  logic [N_TP-1:0] tp;
  logic [PW-1:0]   phase;
  logic            mct_end;
  logic            stopped;
  logic            tp_err;

  modport master (
    output en, stop, step, restart,
    input  tp, phase, mct_end, stopped, tp_err
  );

  modport slave (
    input  en, stop, step, restart,
    output tp, phase, mct_end, stopped, tp_err
  );
endinterface

// File: rtl/timepulse_gen_tp_ring.sv
// One-hot timepulse ring: rotate left one bit, load T01, or hold.
// Latency: one clock from i_load/i_rot to o_tp.
// Backpressure: none; holds whenever neither load nor rotate is asserted.
module tp_ring
  import agc_timing_pkg::*;
#(
  parameter int N_TP = N_TP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_rot,
  output logic [N_TP-1:0] o_tp
);

  logic [N_TP-1:0] r_tp;

  // Load wins over rotate; rotation from the top bit wraps back to T01
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tp <= N_TP'(1) << TP_T01;
    end else if (i_load) begin
      r_tp <= N_TP'(1) << TP_T01;
    end else if (i_rot) begin
      r_tp <= {r_tp[N_TP-2:0], r_tp[N_TP-1]};
    end
  end

  assign o_tp = r_tp;

endmodule

// File: rtl/timepulse_gen.sv
// One-hot timepulse sequencer with phase index, MCT-end strobe, stop/step/restart.
// Latency: one clock from any sampled input to every output (all outputs registered).
// Backpressure: en=0 freezes all state; stop parks at T_N/last phase. Optional macro TP_ONEHOT_CHECK_EN.
module timepulse_gen
  import agc_timing_pkg::*;
#(
  parameter int PHASES_PER_TP = PHASES_PER_TP_DEF,
  parameter int N_TP          = N_TP_DEF
) (
  input  logic           clk,
  input  logic           rst,
  timepulse_gen_if.slave bus
);

  localparam int            PW      = phase_w(PHASES_PER_TP);
  localparam logic [PW-1:0] PH_LAST = PW'(PHASES_PER_TP - 1);

  run_state_e      r_state;
  run_state_e      w_state_nxt;
  logic [PW-1:0]   r_phase;
  logic [PW-1:0]   w_phase_nxt;
  logic            r_mct_end;
  logic            w_mct_nxt;
  logic            w_adv;
  logic            w_phase_last;
  logic            w_at_last;
  logic            w_rot;
  logic [N_TP-1:0] w_tp;

  assign w_phase_last = (r_phase == PH_LAST);
  assign w_at_last    = w_tp[N_TP-1] && w_phase_last;
  assign w_rot        = w_adv && w_phase_last;

  tp_ring #(.N_TP(N_TP)) u_ring (
    .clk    (clk),
    .rst    (rst),
    .i_load (bus.restart),
    .i_rot  (w_rot),
    .o_tp   (w_tp)
  );

  // State, phase and strobe registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_phase   <= '0;
      r_mct_end <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_mct_end <= w_mct_nxt;
    end
  end

  // Run/stop decision: restart > step/stop release > normal advance
  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    w_mct_nxt   = 1'b0;
    if (bus.restart) begin
      w_state_nxt = ST_RUN;
    end else if (r_state == ST_STOPPED) begin
      // Parked at T_N/last: a step performs the pending wrap immediately
      if (bus.step && bus.en) begin
        w_state_nxt = ST_RUN;
        w_adv       = 1'b1;
        w_mct_nxt   = 1'b1;
      end else if (!bus.stop) begin
        w_state_nxt = ST_RUN;
      end
    end else if (bus.en) begin
      if (w_at_last && bus.stop) begin
        w_state_nxt = ST_STOPPED;
      end else begin
        w_adv     = 1'b1;
        w_mct_nxt = w_at_last;
      end
    end
  end

  // Phase index: wraps to 0 on the cycle the ring rotates
  always_comb begin
    w_phase_nxt = r_phase;
    if (bus.restart) begin
      w_phase_nxt = '0;
    end else if (w_adv) begin
      w_phase_nxt = w_phase_last ? '0 : r_phase + PW'(1);
    end
  end

  assign bus.tp      = w_tp;
  assign bus.phase   = r_phase;
  assign bus.mct_end = r_mct_end;
  assign bus.stopped = (r_state == ST_STOPPED);

`ifdef TP_ONEHOT_CHECK_EN
  logic r_tp_err;

  // Sticky flag raised the cycle after the ring is seen not one-hot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tp_err <= 1'b0;
    end else if (bus.restart) begin
      r_tp_err <= 1'b0;
    end else if (!$onehot(w_tp)) begin
      r_tp_err <= 1'b1;
    end
  end

  assign bus.tp_err = r_tp_err;
`else
  assign bus.tp_err = 1'b0;
`endif

endmodule

// File: tb/tb_timepulse_gen.sv
// Bench for timepulse_gen: directed scenarios plus random controls against a position-counter model.
// Latency: outputs compared on every falling edge, half a cycle after the updating edge.
// Backpressure: en, stop, step and restart are driven on falling edges only.
module tb_timepulse_gen;

  localparam int P       = 4;
  localparam int NT      = 12;
  localparam int MCT_LEN = P * NT;
  localparam int LAST    = MCT_LEN - 1;

  logic clk;
  logic rst;

  timepulse_gen_if #(.N_TP(NT), .PW(2)) bus ();

  timepulse_gen #(.PHASES_PER_TP(P), .N_TP(NT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int mct_cnt  = 0;
  bit check_on = 1'b1;

  // Reference model: a single position 0..MCT_LEN-1 within the MCT
  int m_pos     = 0;
  bit m_stopped = 1'b0;
  bit m_mct     = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pos = 0; m_stopped = 1'b0; m_mct = 1'b0;
    end else if (bus.restart) begin
      m_pos = 0; m_stopped = 1'b0; m_mct = 1'b0;
    end else if (m_stopped) begin
      m_mct = 1'b0;
      if (bus.step && bus.en) begin
        m_pos = 0; m_stopped = 1'b0; m_mct = 1'b1;
      end else if (!bus.stop) begin
        m_stopped = 1'b0;
      end
    end else if (bus.en) begin
      if (m_pos == LAST && bus.stop) begin
        m_stopped = 1'b1; m_mct = 1'b0;
      end else begin
        m_mct = (m_pos == LAST);
        m_pos = (m_pos + 1) % MCT_LEN;
      end
    end else begin
      m_mct = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (check_on) begin
      logic [NT-1:0] e_tp;
      e_tp = NT'(1) << (m_pos / P);
      chk("tp",      int'(bus.tp),      int'(e_tp));
      chk("phase",   int'(bus.phase),   m_pos % P);
      chk("mct_end", int'(bus.mct_end), int'(m_mct));
      chk("stopped", int'(bus.stopped), int'(m_stopped));
      chk("tp_err",  int'(bus.tp_err),  0);
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (bus.mct_end) mct_cnt++;
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0;
    bus.en = 1'b0; bus.stop = 1'b0; bus.step = 1'b0; bus.restart = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tp",      int'(bus.tp),      1);
    chk("rst_phase",   int'(bus.phase),   0);
    chk("rst_stopped", int'(bus.stopped), 0);
    chk("rst_mct",     int'(bus.mct_end), 0);
    rst = 1'b1;

    // One full MCT with continuous enable
    bus.en = 1'b1; mct_cnt = 0;
    for (int i = 1; i <= MCT_LEN; i++) begin
      @(negedge clk);
      if (i == 4)  chk("t02_after4", int'(bus.tp), 12'h002);
      if (i == 47) begin
        chk("no_early_mct", mct_cnt, 0);
        chk("t12_ph3", int'({bus.tp, 2'b00} | 14'(bus.phase)), int'({12'h800, 2'b11}));
      end
      if (bus.mct_end) mct_cnt++;
    end
    chk("mct_at48", int'(bus.mct_end), 1);
    chk("wrap_t01", int'(bus.tp), 1);
    chk("wrap_ph0", int'(bus.phase), 0);

    // Stop raised at T05 parks at T12/3
    run(16);
    chk("at_t05", int'(bus.tp), 12'h010);
    bus.stop = 1'b1; mct_cnt = 0;
    run(32 + 20);
    chk("stop_stopped", int'(bus.stopped), 1);
    chk("stop_tp",      int'(bus.tp),      12'h800);
    chk("stop_phase",   int'(bus.phase),   3);
    chk("stop_no_mct",  mct_cnt, 0);

    // Single step while stop held: one MCT then park again
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    chk("step_mct", int'(bus.mct_end), 1);
    chk("step_tp",  int'(bus.tp), 1);
    mct_cnt = 0;
    run(47);
    chk("step_not_yet", int'(bus.stopped), 0);
    run(1);
    chk("step_restop", int'(bus.stopped), 1);
    chk("step_one_mct", mct_cnt, 0);

    // Stop release: clears stopped, then the pending wrap happens
    bus.stop = 1'b0;
    @(negedge clk);
    chk("rel_clear", int'(bus.stopped), 0);
    chk("rel_hold",  int'(bus.tp), 12'h800);
    @(negedge clk);
    chk("rel_wrap", int'(bus.mct_end), 1);

    // Alternating enable: 96 clocks per MCT
    mct_cnt = 0;
    for (int i = 0; i < 2 * MCT_LEN; i++) begin
      bus.en = (i % 2 == 0);
      @(negedge clk);
      if (bus.mct_end) mct_cnt++;
    end
    chk("alt_mct_cnt", mct_cnt, 1);
    chk("alt_tp", int'(bus.tp), 1);
    chk("alt_phase", int'(bus.phase), 0);

    // Restart at T07 phase 2 with stop pending
    bus.en = 1'b1;
    run(26);
    chk("pre_rs_tp", int'(bus.tp), 12'h040);
    chk("pre_rs_ph", int'(bus.phase), 2);
    bus.stop = 1'b1; bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0; bus.stop = 1'b0;
    chk("rs_tp", int'(bus.tp), 1);
    chk("rs_phase", int'(bus.phase), 0);
    chk("rs_stopped", int'(bus.stopped), 0);
    chk("rs_mct", int'(bus.mct_end), 0);

    // Asynchronous reset mid-MCT
    run(10);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_tp", int'(bus.tp), 1);
    chk("arst_phase", int'(bus.phase), 0);
    @(negedge clk);
    rst = 1'b1;

    // Random control stimulus
    for (int i = 0; i < 3000; i++) begin
      bus.en      = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 19) == 0) bus.stop = ~bus.stop;
      bus.step    = ($urandom_range(0, 19) == 0);
      bus.restart = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    bus.en = 1'b0; bus.stop = 1'b0; bus.step = 1'b0; bus.restart = 1'b0;
    @(negedge clk);

`ifdef TP_ONEHOT_CHECK_EN
    check_on = 1'b0;
    force dut.u_ring.r_tp = 12'h003;
    @(negedge clk);
    chk("err_set", int'(bus.tp_err), 1);
    release dut.u_ring.r_tp;
    run(5);
    chk("err_sticky", int'(bus.tp_err), 1);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    chk("err_clear", int'(bus.tp_err), 0);
    check_on = 1'b1;
    run(5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
